// File: rtl/dfe_output_buffer.sv
// Elastic FIFO output stage for the DFE chain: strobe-in, valid/ready-out, frame marker, sticky overrun.
// Optional drop counter built only when DFE_OUTBUF_DROPCNT_EN is defined.
module dfe_output_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int FRAME_LEN  = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     out_ready,
    input  logic                     clear_ovf,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = $clog2(FRAME_LEN);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [FW-1:0] LAST = FW'(FRAME_LEN - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         lvl;
    logic [FW-1:0]         frame_cnt;
    logic                  ovf;
    logic                  full, pop, push, drop;

    assign full      = (lvl == FULL);
    assign out_valid = (lvl != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push      = in_valid & (~full | pop);
    assign drop      = in_valid & full & ~pop;

    assign out_data  = mem[rd_ptr];
    assign out_last  = out_valid & (frame_cnt == LAST);
    assign overflow  = ovf;
    assign level     = lvl;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lvl       <= '0;
            frame_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                frame_cnt <= (frame_cnt == LAST) ? '0 : frame_cnt + 1'b1;
            end
            if (push && !pop)      lvl <= lvl + 1'b1;
            else if (pop && !push) lvl <= lvl - 1'b1;
        end
    end

    // Set has priority over clear so a drop in the clearing cycle is never lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            ovf <= 1'b0;
        else if (drop)      ovf <= 1'b1;
        else if (clear_ovf) ovf <= 1'b0;
    end

`ifdef DFE_OUTBUF_DROPCNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                       drop_cnt <= '0;
        else if (drop && clear_ovf)    drop_cnt <= 16'd1;
        else if (clear_ovf)            drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_dfe_output_buffer.sv
// Directed bench for dfe_output_buffer (DEPTH=8, FRAME_LEN=4) with a small queue model for streaming phases.
module tb_dfe_output_buffer;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    localparam int FL = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          clear_ovf = 1'b0;
    logic          out_valid, out_last, overflow;
    logic [DW-1:0] out_data;
    logic [3:0]    level;
    logic [15:0]   drop_count;

    dfe_output_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .clear_ovf(clear_ovf), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .overflow(overflow),
        .level(level), .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] q[$];
    int            fc = 0;
    int            xfer = 0;
    int            lasts[$];
    logic          ovf_m = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

`ifdef DFE_OUTBUF_DROPCNT_EN
    localparam logic [15:0] EXP_DROPS = 16'd3;
`else
    localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Applies reset in mid-cycle and checks outputs before any clock edge.
    task automatic do_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_level", level, 0);
        chk("rst_drops", drop_count, 0);
        q.delete();
        lasts.delete();
        fc = 0;
        xfer = 0;
        ovf_m = 1'b0;
        prev_stall = 1'b0;
        #1;
        RST = 1'b0;
        tick();
    endtask

    // One clock of stimulus, checked against the queue model before the edge.
    task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy);
        logic pop, push;
        in_valid = iv;
        in_data = id;
        out_ready = ordy;
        chk("s_valid", out_valid, q.size() != 0);
        chk("s_level", level, q.size());
        if (q.size() != 0) begin
            chk("s_data", out_data, q[0]);
            chk("s_last", out_last, fc == FL - 1);
        end
        if (prev_stall) chk("s_stable", out_data, prev_data);
        pop = (q.size() != 0) && ordy;
        push = iv && (q.size() < DEPTH || pop);
        prev_stall = (q.size() != 0) && !ordy;
        prev_data = out_data;
        tick();
        if (pop) begin
            void'(q.pop_front());
            xfer++;
            if (fc == FL - 1) lasts.push_back(xfer);
            fc = (fc == FL - 1) ? 0 : fc + 1;
        end
        if (push) q.push_back(id);
        if (iv && !push) ovf_m = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        chk("init_valid", out_valid, 0);
        chk("init_level", level, 0);
        chk("init_data", out_data, 0);
        RST = 1'b0;
        tick();

        // Fill with out_ready low
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("fill_level", level, 8);
        chk("fill_ovf", overflow, 0);
        chk("fill_head", out_data, 16'h0001);
        chk("fill_last", out_last, 0);

        // Overrun: three strobes into a full FIFO
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 16'hDEAD;
            tick();
        end
        in_valid = 1'b0;
        chk("ovr_flag", overflow, 1);
        chk("ovr_drops", drop_count, EXP_DROPS);
        chk("ovr_level", level, 8);
        chk("ovr_head", out_data, 16'h0001);

        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_drops", drop_count, 0);

        // Full with simultaneous push and pop
        in_valid = 1'b1;
        in_data = 16'h7FFF;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_level", level, 8);
        chk("pp_head", out_data, 16'h0002);
        chk("pp_ovf", overflow, 0);
        chk("pp_drops", drop_count, 0);

        // Drain; model picks up after one delivered transfer
        q = '{16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8, 16'h7FFF};
        fc = 1;
        xfer = 1;
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1);
        chk("drain_nlast", lasts.size(), 2);
        if (lasts.size() == 2) begin
            chk("drain_last0", lasts[0], 4);
            chk("drain_last1", lasts[1], 8);
        end

        // Framing: 10 samples streamed
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        chk("frm_xfers", xfer, 10);
        chk("frm_nlast", lasts.size(), 2);
        if (lasts.size() == 2) begin
            chk("frm_last0", lasts[0], 4);
            chk("frm_last1", lasts[1], 8);
        end

        // Reset mid-frame restarts the frame count
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h0200 + i), 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h0300 + i), 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1);
        chk("rfrm_nlast", lasts.size(), 1);
        if (lasts.size() != 0) chk("rfrm_last0", lasts[0], 4);

        // Latency: single sample into empty FIFO
        chk("lat_pre", out_valid, 0);
        in_valid = 1'b1;
        in_data = 16'h8000;
        tick();
        in_valid = 1'b0;
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 16'h8000);
        chk("lat_level", level, 1);

        // Back-pressure: one input every 3 cycles, random ready
        do_reset();
        for (int k = 0; k < 600; k++)
            cycle(k % 3 == 0, 16'($urandom), $urandom_range(3) != 0);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);
        chk("bp_xfers", xfer, 200);
        chk("bp_ovf", overflow, 0);
        chk("bp_ovf_model", ovf_m, 0);
        chk("bp_drops", drop_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
